video_probe_tap: RTL and testbench

Registered probe-conditioning stage that sits directly upstream of the on-chip ChipWatcher logic analyzer in the camera-to-HDMI video path. It taps a video stream (vsync, hsync, data-enable, pixel data), delays it by a fixed two-cycle pipeline, and drives the analyzer's probe inputs with the following signals, all timing-aligned to the delayed stream:
- per-line pixel index
- per-frame line index
- frame counter
- line-length error flags
- a selectable one-cycle trigger strobe

---
 rtl/video_probe_tap.sv | 215 +++++++++++++++++++++
 tb/tb_video_probe_tap.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_probe_tap.sv
// video_probe_tap: two-stage registered tap of a video stream that feeds the
// ChipWatcher probe inputs with the delayed stream plus pixel/line/frame
// counters, line-length error flags and a selectable trigger strobe. All
// counter outputs are aligned with the delayed stream, not with the raw input.
module video_probe_tap #(
  parameter int DATA_W = 16,
  parameter int PIX_W  = 12,
  parameter int LINE_W = 11,
  parameter int FRM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              trig_sel_i,
  output logic              probe_vs,
  output logic              probe_hs,
  output logic              probe_de,
  output logic [DATA_W-1:0] probe_data,
  output logic [PIX_W-1:0]  probe_pix_cnt,
  output logic [LINE_W-1:0] probe_line_cnt,
  output logic [FRM_W-1:0]  probe_frame_cnt,
  output logic              probe_len_err,
  output logic [7:0]        probe_err_cnt,
  output logic              probe_in_frame,
  output logic              probe_trig
);

  typedef enum logic {
    WAIT_VS  = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
  localparam logic [PIX_W-1:0]  PIX_ONE  = PIX_W'(1);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
  localparam logic [FRM_W-1:0]  FRM_ONE  = FRM_W'(1);
  localparam logic [7:0]        ERR_MAX  = 8'hFF;

  state_t state_q, state_d;

  // Stage 1: raw input copies (also the reference for edge detection)
  logic              s1_vs_q, s1_vs_d;
  logic              s1_hs_q, s1_hs_d;
  logic              s1_de_q, s1_de_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  // Stage 1 aligned counters and flags
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [PIX_W-1:0]  ref_len_q, ref_len_d;
  logic              ref_valid_q, ref_valid_d;
  logic              len_err_q, len_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              trig_q, trig_d;

  // Stage 2: registered probe outputs
  logic              probe_vs_q, probe_vs_d;
  logic              probe_hs_q, probe_hs_d;
  logic              probe_de_q, probe_de_d;
  logic [DATA_W-1:0] probe_data_q, probe_data_d;
  logic [PIX_W-1:0]  probe_pix_cnt_q, probe_pix_cnt_d;
  logic [LINE_W-1:0] probe_line_cnt_q, probe_line_cnt_d;
  logic [FRM_W-1:0]  probe_frame_cnt_q, probe_frame_cnt_d;
  logic              probe_len_err_q, probe_len_err_d;
  logic [7:0]        probe_err_cnt_q, probe_err_cnt_d;
  logic              probe_in_frame_q, probe_in_frame_d;
  logic              probe_trig_q, probe_trig_d;

  logic              vs_rise;
  logic              de_rise;
  logic              de_fall;
  logic [PIX_W-1:0]  line_len;

  assign vs_rise  = vs_i & ~s1_vs_q;
  assign de_rise  = de_i & ~s1_de_q;
  assign de_fall  = ~de_i & s1_de_q;
  // Length of the line that just ended: last pixel index + 1, saturating
  assign line_len = (pix_cnt_q == PIX_MAX) ? PIX_MAX : (pix_cnt_q + PIX_ONE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_VS;
    else        state_q <= state_d;
  end

  // FSM next state: any vsync rise enters (or restarts) a frame
  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = IN_FRAME;
  end

  // Datapath next state: stage-1 capture, counters, error check, probe stage
  always_comb begin
    s1_vs_d     = vs_i;
    s1_hs_d     = hs_i;
    s1_de_d     = de_i;
    s1_data_d   = data_i;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ref_len_d   = ref_len_q;
    ref_valid_d = ref_valid_q;
    err_cnt_d   = err_cnt_q;
    len_err_d   = 1'b0;
    trig_d      = 1'b0;

    if (vs_rise) begin
      // Frame start wins over everything, including a coincident DE fall
      frame_cnt_d = frame_cnt_q + FRM_ONE;
      line_cnt_d  = '0;
      pix_cnt_d   = '0;
      ref_valid_d = 1'b0;
      trig_d      = ~trig_sel_i;
    end else if (state_q == IN_FRAME) begin
      if (de_rise) begin
        pix_cnt_d = '0;
      end else if (de_i) begin
        if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + PIX_ONE;
      end else if (de_fall) begin
        if (!ref_valid_q) begin
          ref_len_d   = line_len;
          ref_valid_d = 1'b1;
        end else if (line_len != ref_len_q) begin
          len_err_d = 1'b1;
          trig_d    = trig_sel_i;
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'd1;
        end
        if (line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + LINE_ONE;
      end
    end

    probe_vs_d        = s1_vs_q;
    probe_hs_d        = s1_hs_q;
    probe_de_d        = s1_de_q;
    probe_data_d      = s1_data_q;
    probe_pix_cnt_d   = pix_cnt_q;
    probe_line_cnt_d  = line_cnt_q;
    probe_frame_cnt_d = frame_cnt_q;
    probe_len_err_d   = len_err_q;
    probe_err_cnt_d   = err_cnt_q;
    probe_in_frame_d  = (state_q == IN_FRAME);
    probe_trig_d      = trig_q;
  end

  // Datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vs_q           <= 1'b0;
      s1_hs_q           <= 1'b0;
      s1_de_q           <= 1'b0;
      s1_data_q         <= '0;
      pix_cnt_q         <= '0;
      line_cnt_q        <= '0;
      frame_cnt_q       <= '0;
      ref_len_q         <= '0;
      ref_valid_q       <= 1'b0;
      len_err_q         <= 1'b0;
      err_cnt_q         <= '0;
      trig_q            <= 1'b0;
      probe_vs_q        <= 1'b0;
      probe_hs_q        <= 1'b0;
      probe_de_q        <= 1'b0;
      probe_data_q      <= '0;
      probe_pix_cnt_q   <= '0;
      probe_line_cnt_q  <= '0;
      probe_frame_cnt_q <= '0;
      probe_len_err_q   <= 1'b0;
      probe_err_cnt_q   <= '0;
      probe_in_frame_q  <= 1'b0;
      probe_trig_q      <= 1'b0;
    end else begin
      s1_vs_q           <= s1_vs_d;
      s1_hs_q           <= s1_hs_d;
      s1_de_q           <= s1_de_d;
      s1_data_q         <= s1_data_d;
      pix_cnt_q         <= pix_cnt_d;
      line_cnt_q        <= line_cnt_d;
      frame_cnt_q       <= frame_cnt_d;
      ref_len_q         <= ref_len_d;
      ref_valid_q       <= ref_valid_d;
      len_err_q         <= len_err_d;
      err_cnt_q         <= err_cnt_d;
      trig_q            <= trig_d;
      probe_vs_q        <= probe_vs_d;
      probe_hs_q        <= probe_hs_d;
      probe_de_q        <= probe_de_d;
      probe_data_q      <= probe_data_d;
      probe_pix_cnt_q   <= probe_pix_cnt_d;
      probe_line_cnt_q  <= probe_line_cnt_d;
      probe_frame_cnt_q <= probe_frame_cnt_d;
      probe_len_err_q   <= probe_len_err_d;
      probe_err_cnt_q   <= probe_err_cnt_d;
      probe_in_frame_q  <= probe_in_frame_d;
      probe_trig_q      <= probe_trig_d;
    end
  end

  assign probe_vs        = probe_vs_q;
  assign probe_hs        = probe_hs_q;
  assign probe_de        = probe_de_q;
  assign probe_data      = probe_data_q;
  assign probe_pix_cnt   = probe_pix_cnt_q;
  assign probe_line_cnt  = probe_line_cnt_q;
  assign probe_frame_cnt = probe_frame_cnt_q;
  assign probe_len_err   = probe_len_err_q;
  assign probe_err_cnt   = probe_err_cnt_q;
  assign probe_in_frame  = probe_in_frame_q;
  assign probe_trig      = probe_trig_q;

endmodule

// File: tb/tb_video_probe_tap.sv
// Bench for video_probe_tap: directed video timing, a frame/line/pixel model
// that predicts every probe output two cycles later, and literal checkpoints.
module tb_video_probe_tap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_i;
  logic        hs_i;
  logic        de_i;
  logic [15:0] data_i;
  logic        trig_sel_i;
  logic        probe_vs;
  logic        probe_hs;
  logic        probe_de;
  logic [15:0] probe_data;
  logic [11:0] probe_pix_cnt;
  logic [10:0] probe_line_cnt;
  logic [15:0] probe_frame_cnt;
  logic        probe_len_err;
  logic [7:0]  probe_err_cnt;
  logic        probe_in_frame;
  logic        probe_trig;

  // Clock
  always #5 clk = ~clk;

  video_probe_tap dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vs_i            (vs_i),
    .hs_i            (hs_i),
    .de_i            (de_i),
    .data_i          (data_i),
    .trig_sel_i      (trig_sel_i),
    .probe_vs        (probe_vs),
    .probe_hs        (probe_hs),
    .probe_de        (probe_de),
    .probe_data      (probe_data),
    .probe_pix_cnt   (probe_pix_cnt),
    .probe_line_cnt  (probe_line_cnt),
    .probe_frame_cnt (probe_frame_cnt),
    .probe_len_err   (probe_len_err),
    .probe_err_cnt   (probe_err_cnt),
    .probe_in_frame  (probe_in_frame),
    .probe_trig      (probe_trig)
  );

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [15:0] data;
    logic [11:0] pix;
    logic [10:0] line;
    logic [15:0] frame;
    logic        len_err;
    logic [7:0]  err;
    logic        in_frame;
    logic        trig;
  } rec_t;

  // Scoreboard: expected probe record per cycle
  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  int   trig_seen = 0;
  int   err_seen = 0;
  logic [15:0] data_ctr;

  // Model state in frame/line terms; m_count = pixels seen in current line
  bit m_in_frame;
  int m_frame;
  int m_line;
  int m_count;
  int m_ref;
  bit m_ref_valid;
  int m_err;
  bit m_prev_vs;
  bit m_prev_de;

  task automatic model_reset();
    m_in_frame = 0; m_frame = 0; m_line = 0; m_count = 0;
    m_ref = 0; m_ref_valid = 0; m_err = 0; m_prev_vs = 0; m_prev_de = 0;
  endtask

  task automatic model_step(input logic vs, input logic hs, input logic de,
                            input logic [15:0] d, output rec_t r);
    bit vs_rise, de_rise, de_fall;
    int len, pix;
    vs_rise = vs && !m_prev_vs;
    de_rise = de && !m_prev_de;
    de_fall = !de && m_prev_de;
    r = '0;
    if (vs_rise) begin
      m_in_frame  = 1;
      m_frame     = m_frame + 1;
      m_line      = 0;
      m_count     = de ? 1 : 0;
      m_ref_valid = 0;
      r.trig      = ~trig_sel_i;
    end else if (m_in_frame) begin
      if (de) begin
        m_count = de_rise ? 1 : m_count + 1;
      end else if (de_fall) begin
        len = (m_count > 4095) ? 4095 : m_count;
        if (!m_ref_valid) begin
          m_ref = len;
          m_ref_valid = 1;
        end else if (len != m_ref) begin
          r.len_err = 1'b1;
          r.trig    = trig_sel_i;
          if (m_err < 255) m_err = m_err + 1;
        end
        if (m_line < 2047) m_line = m_line + 1;
      end
    end
    m_prev_vs = vs;
    m_prev_de = de;
    pix = (m_count == 0) ? 0 : ((m_count - 1 > 4095) ? 4095 : m_count - 1);
    r.vs       = vs;
    r.hs       = hs;
    r.de       = de;
    r.data     = d;
    r.pix      = 12'(pix);
    r.line     = 11'(m_line);
    r.frame    = 16'(m_frame);
    r.err      = 8'(m_err);
    r.in_frame = m_in_frame;
  endtask

  function automatic rec_t dut_rec();
    rec_t r;
    r.vs = probe_vs; r.hs = probe_hs; r.de = probe_de; r.data = probe_data;
    r.pix = probe_pix_cnt; r.line = probe_line_cnt; r.frame = probe_frame_cnt;
    r.len_err = probe_len_err; r.err = probe_err_cnt;
    r.in_frame = probe_in_frame; r.trig = probe_trig;
    return r;
  endfunction

  // Driver: one input cycle, then the per-cycle model comparison
  task automatic cyc(input logic vs, input logic hs, input logic de, input logic [15:0] d);
    rec_t r, e, a;
    vs_i = vs; hs_i = hs; de_i = de; data_i = d;
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
    end else begin
      model_step(vs, hs, de, d, r);
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc_no++;
    a = dut_rec();
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL cycle %0d: model queue empty, dut=%h", cyc_no, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle %0d: dut=%h model=%h", cyc_no, a, e);
      end
    end
    if (a.trig === 1'b1) trig_seen++;
    if (a.len_err === 1'b1) err_seen++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic de);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, de, data_ctr);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic send_line(input int npix, input int gap);
    for (int i = 0; i < npix; i++) begin
      cyc(1'b0, 1'b0, 1'b1, data_ctr);
      data_ctr = data_ctr + 16'd1;
    end
    for (int i = 0; i < gap; i++) cyc(1'b0, (i == 0), 1'b0, 16'h0);
  endtask

  task automatic vs_pulse(input int exp_frame);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("frame_start_cnt", 32'(probe_frame_cnt), exp_frame);
    idle(2);
  endtask

  int t0;
  int e0;
  rec_t z;

  initial begin
    rst_n = 1'b0; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = 16'h0;
    trig_sel_i = 1'b0; data_ctr = 16'h1000;
    model_reset();

    // Reset state
    do_reset(1'b0);
    do_reset(1'b0);
    chk("reset_frame_cnt", 32'(probe_frame_cnt), 0);
    chk("reset_in_frame", 32'(probe_in_frame), 0);

    // DE activity before the first vsync is ignored
    send_line(8, 4);
    send_line(8, 4);
    chk("pre_vs_pix", 32'(probe_pix_cnt), 0);
    chk("pre_vs_line", 32'(probe_line_cnt), 0);
    chk("pre_vs_in_frame", 32'(probe_in_frame), 0);

    // Three frames of 4 lines x 8 pixels, frame-start trigger
    t0 = trig_seen;
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      if (f == 0) chk("in_frame_lag", 32'(probe_in_frame), 0);
      cyc(1'b1, 1'b0, 1'b0, 16'h0);
      chk("frame_start_cnt", 32'(probe_frame_cnt), f + 1);
      if (f == 0) chk("in_frame_set", 32'(probe_in_frame), 1);
      idle(2);
      for (int l = 0; l < 4; l++) send_line(8, 4);
      chk("last_pix", 32'(probe_pix_cnt), 7);
      chk("lines_per_frame", 32'(probe_line_cnt), 4);
    end
    idle(3);
    chk("frame_trig_count", trig_seen - t0, 3);
    chk("no_len_err", err_seen, 0);

    // Lines 8,8,7,8 with error-sourced trigger
    trig_sel_i = 1'b1;
    t0 = trig_seen;
    e0 = err_seen;
    vs_pulse(4);
    send_line(8, 4);
    send_line(8, 4);
    send_line(7, 4);
    chk("short_line_err_pulse", err_seen - e0, 1);
    chk("short_line_err_cnt", 32'(probe_err_cnt), 1);
    send_line(8, 4);
    idle(2);
    chk("err_trig_count", trig_seen - t0, 1);
    chk("err_cnt_after_frame", 32'(probe_err_cnt), 1);

    // vsync rises in the same cycle DE falls on a short line
    e0 = err_seen;
    vs_pulse(5);
    send_line(8, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, data_ctr);
      data_ctr = data_ctr + 16'd1;
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("simul_frame_cnt", 32'(probe_frame_cnt), 6);
    idle(3);
    chk("simul_line_cnt", 32'(probe_line_cnt), 0);
    chk("simul_pix_cnt", 32'(probe_pix_cnt), 0);
    chk("simul_no_err", err_seen - e0, 0);

    // One-cycle reset in the middle of a line
    vs_pulse(7);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, data_ctr);
      data_ctr = data_ctr + 16'd1;
    end
    do_reset(1'b1);
    z = dut_rec();
    n_cmp++;
    if (z !== '0) begin
      n_fail++;
      $display("FAIL reset_all_zero: got %h expected 0", z);
    end
    cyc(1'b0, 1'b0, 1'b1, data_ctr);
    cyc(1'b0, 1'b0, 1'b1, data_ctr);
    idle(3);
    chk("post_reset_in_frame", 32'(probe_in_frame), 0);
    chk("post_reset_err_cnt", 32'(probe_err_cnt), 0);
    vs_pulse(1);

    // 4100-pixel reference line, then 300 mismatched lines
    send_line(4100, 4);
    chk("pix_saturate", 32'(probe_pix_cnt), 4095);
    e0 = err_seen;
    for (int i = 0; i < 300; i++) send_line(4, 2);
    idle(3);
    chk("err_cnt_saturate", 32'(probe_err_cnt), 255);
    chk("err_pulse_count", err_seen - e0, 300);
    chk("long_frame_lines", 32'(probe_line_cnt), 301);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
